// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit.
// Tracks in-flight destination tags for EX/MEM/WB, requests a stall to ID on
// a load-use dependency, and registers per-operand forwarding selects so they
// line up with the instruction as it sits in EX.
module fwd_hazard_unit #(
  parameter int unsigned NUM_SRC   = 2,
  parameter int unsigned AW        = 5,
  parameter int unsigned WB_BYPASS = 1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [NUM_SRC*AW-1:0] id_rs,
  input  logic [NUM_SRC-1:0]    id_rs_used,
  input  logic [AW-1:0]         id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  flush,
  input  logic                  freeze,
  output logic                  stall,
  output logic [NUM_SRC*2-1:0]  ex_fwd_sel,
  output logic [CNT_W-1:0]      stall_cnt
);

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] rd;
    logic          reg_write;
    logic          mem_read;
  } tag_t;

  tag_t ex_q, mem_q, wb_q;

  logic                 ex_wr, mem_wr, wb_wr;
  logic                 load_use;
  logic                 advance;
  logic [NUM_SRC*2-1:0] sel_d;

  // An entry only matters when it will actually write a non-zero register
  assign ex_wr  = ex_q.valid  && ex_q.reg_write  && (ex_q.rd  != '0);
  assign mem_wr = mem_q.valid && mem_q.reg_write && (mem_q.rd != '0);
  assign wb_wr  = wb_q.valid  && wb_q.reg_write  && (wb_q.rd  != '0);

  // Per-operand select (youngest producer wins) and load-use detection
  always_comb begin
    sel_d    = '0;
    load_use = 1'b0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      if (id_rs_used[k] && (id_rs[k*AW +: AW] != '0)) begin
        if (ex_wr && (ex_q.rd == id_rs[k*AW +: AW])) begin
          sel_d[k*2 +: 2] = 2'b01;
          if (ex_q.mem_read) begin
            load_use = 1'b1;
          end
        end else if (mem_wr && (mem_q.rd == id_rs[k*AW +: AW])) begin
          sel_d[k*2 +: 2] = 2'b10;
        end else if ((WB_BYPASS != 0) && wb_wr && (wb_q.rd == id_rs[k*AW +: AW])) begin
          sel_d[k*2 +: 2] = 2'b11;
        end
      end
    end
  end

  // flush kills the ID instruction, so it also cancels any stall request
  assign stall   = id_valid && !flush && load_use;
  assign advance = id_valid && !stall && !flush;

  // Tag pipeline and registered selects; freeze holds everything, reset overrides
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q       <= '0;
      mem_q      <= '0;
      wb_q       <= '0;
      ex_fwd_sel <= '0;
    end else if (!freeze) begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      if (advance) begin
        ex_q       <= {1'b1, id_rd, id_reg_write, id_mem_read};
        ex_fwd_sel <= sel_d;
      end else begin
        ex_q       <= '0;
        ex_fwd_sel <= '0;
      end
    end
  end

  // Saturating count of effective stall cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stall && !freeze && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed self-checking bench for fwd_hazard_unit.
// Two instances share the stimulus: dut_a uses defaults (WB bypass on,
// 16-bit counter), dut_b has WB bypass off and a 4-bit counter.
module tb_fwd_hazard_unit;

  logic        clk;
  logic        reset;
  logic        id_valid;
  logic [9:0]  id_rs;
  logic [1:0]  id_rs_used;
  logic [4:0]  id_rd;
  logic        id_reg_write;
  logic        id_mem_read;
  logic        flush;
  logic        freeze;

  logic        stall_a, stall_b;
  logic [3:0]  sel_a, sel_b;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;

  int tests = 0;
  int fails = 0;

  fwd_hazard_unit #(
    .NUM_SRC(2), .AW(5), .WB_BYPASS(1), .CNT_W(16)
  ) dut_a (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs),
    .id_rs_used(id_rs_used), .id_rd(id_rd), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .flush(flush), .freeze(freeze),
    .stall(stall_a), .ex_fwd_sel(sel_a), .stall_cnt(cnt_a)
  );

  fwd_hazard_unit #(
    .NUM_SRC(2), .AW(5), .WB_BYPASS(0), .CNT_W(4)
  ) dut_b (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs),
    .id_rs_used(id_rs_used), .id_rd(id_rd), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .flush(flush), .freeze(freeze),
    .stall(stall_b), .ex_fwd_sel(sel_b), .stall_cnt(cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Operand 0 in the low field, operand 1 in the high field
  task automatic set_id(input logic v, input logic [4:0] r0, input logic [4:0] r1,
                        input logic [1:0] used, input logic [4:0] rd,
                        input logic rw, input logic mr);
    id_valid     = v;
    id_rs        = {r1, r0};
    id_rs_used   = used;
    id_rd        = rd;
    id_reg_write = rw;
    id_mem_read  = mr;
    #1;
  endtask

  initial begin
    reset  = 1'b1;
    freeze = 1'b0;
    flush  = 1'b0;
    set_id(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
    cyc();
    cyc();
    reset = 1'b0;
    #1;
    chk("reset_stall_a", stall_a, 0);
    chk("reset_sel_a",   sel_a,   0);
    chk("reset_sel_b",   sel_b,   0);
    chk("reset_cnt_a",   cnt_a,   0);
    chk("reset_cnt_b",   cnt_b,   0);

    // add x5 ; sub x6,x5,x5
    set_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b0);
    cyc();
    set_id(1'b1, 5'd5, 5'd5, 2'b11, 5'd6, 1'b1, 1'b0);
    chk("alu_b2b_stall", stall_a, 0);
    cyc();
    chk("alu_b2b_sel_a", sel_a, 4'b0101);
    chk("alu_b2b_sel_b", sel_b, 4'b0101);

    // lw x7 ; consumer reads x1, x7 on operand 1
    set_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1'b1);
    cyc();
    chk("lw_sel_a", sel_a, 0);
    set_id(1'b1, 5'd1, 5'd7, 2'b11, 5'd8, 1'b1, 1'b0);
    chk("loaduse_stall_a", stall_a, 1);
    chk("loaduse_stall_b", stall_b, 1);
    cyc();
    chk("loaduse_bubble_sel", sel_a, 0);
    chk("loaduse_cnt_a", cnt_a, 1);
    chk("loaduse_cnt_b", cnt_b, 1);
    chk("loaduse_stall_once", stall_a, 0);
    cyc();
    chk("loaduse_mem_sel_a", sel_a, 4'b1000);
    chk("loaduse_mem_sel_b", sel_b, 4'b1000);
    chk("loaduse_cnt_hold", cnt_a, 1);

    // priority: EX x3, MEM x3, WB x4 ; consumer rs1=x3 rs2=x4
    set_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd4, 1'b1, 1'b0);
    cyc();
    set_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd3, 1'b1, 1'b0);
    cyc();
    set_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd3, 1'b1, 1'b0);
    cyc();
    set_id(1'b1, 5'd3, 5'd4, 2'b11, 5'd9, 1'b1, 1'b0);
    chk("prio_stall", stall_a, 0);
    cyc();
    chk("prio_sel_bypass",   sel_a, 4'b1101);
    chk("prio_sel_nobypass", sel_b, 4'b0001);

    // x0 load in EX; rs1=x0 used, rs2=x9 (in MEM) unused
    set_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 1'b1, 1'b1);
    cyc();
    set_id(1'b1, 5'd0, 5'd9, 2'b01, 5'd11, 1'b0, 1'b0);
    chk("x0_stall", stall_a, 0);
    cyc();
    chk("x0_unused_sel_a", sel_a, 0);
    chk("x0_unused_sel_b", sel_b, 0);

    // lw x10,(x9): x9 is now in WB
    set_id(1'b1, 5'd9, 5'd0, 2'b01, 5'd10, 1'b1, 1'b1);
    chk("wb_lw_stall", stall_a, 0);
    cyc();
    chk("wb_lw_sel_a", sel_a, 4'b0011);
    chk("wb_lw_sel_b", sel_b, 4'b0000);

    // freeze for 3 cycles with load-use pending
    freeze = 1'b1;
    set_id(1'b1, 5'd10, 5'd0, 2'b01, 5'd12, 1'b1, 1'b0);
    chk("frz_stall_start", stall_a, 1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("frz_stall", stall_a, 1);
      chk("frz_sel_a", sel_a, 4'b0011);
      chk("frz_sel_b", sel_b, 4'b0000);
      chk("frz_cnt_a", cnt_a, 1);
      chk("frz_cnt_b", cnt_b, 1);
    end

    // flush overrides the stall condition
    freeze = 1'b0;
    flush  = 1'b1;
    #1;
    chk("flush_stall", stall_a, 0);
    cyc();
    chk("flush_sel", sel_a, 0);
    chk("flush_cnt", cnt_a, 1);
    flush = 1'b0;
    #1;
    chk("flush_ex_bubble_stall", stall_a, 0);
    cyc();
    chk("flush_mem_sel_a", sel_a, 4'b0010);
    chk("flush_mem_sel_b", sel_b, 4'b0010);

    // 20 load-use stalls: dut_a counts to 21, dut_b saturates at 15
    for (int i = 0; i < 20; i++) begin
      set_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1'b1);
      chk("sat_lw_stall", stall_a, 0);
      cyc();
      set_id(1'b1, 5'd0, 5'd7, 2'b10, 5'd13, 1'b1, 1'b0);
      chk("sat_use_stall", stall_a, 1);
      cyc();
    end
    chk("sat_cnt_a", cnt_a, 21);
    chk("sat_cnt_b", cnt_b, 15);

    // build state, then reset while frozen
    set_id(1'b1, 5'd7, 5'd0, 2'b01, 5'd7, 1'b1, 1'b1);
    chk("pre_rst_stall", stall_a, 0);
    cyc();
    chk("pre_rst_sel", sel_a, 4'b0010);
    set_id(1'b1, 5'd7, 5'd0, 2'b01, 5'd14, 1'b1, 1'b0);
    chk("pre_rst_loaduse", stall_a, 1);
    freeze = 1'b1;
    reset  = 1'b1;
    cyc();
    chk("rst_frz_sel_a", sel_a, 0);
    chk("rst_frz_sel_b", sel_b, 0);
    chk("rst_frz_cnt_a", cnt_a, 0);
    chk("rst_frz_cnt_b", cnt_b, 0);
    chk("rst_frz_stall", stall_a, 0);
    reset  = 1'b0;
    freeze = 1'b0;
    #1;
    chk("post_rst_stall", stall_a, 0);
    cyc();
    chk("post_rst_sel", sel_a, 0);
    chk("post_rst_cnt", cnt_a, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
